register_move_sequencer: RTL
============================

REGISTER_MOVE_SEQUENCER -- requirements
Module: register_move_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE, default 1: number of cycles the source select is held before the destination load asserts; legal range 1..15.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to execute the move in instr; sampled on a rising edge only while in IDLE.
REQ-005 SHALL provide port instr  input  8  MOV8 word with layout 00 ddd sss: bits[5:3] are the destination, bits[2:0] the source.
REQ-006 SHALL provide port ld  output  8  one-hot register load strobes: bit0 A, bit1 B, bit2 C, bit3 D, bit4 M1, bit5 M2, bit6 X, bit7 Y.
REQ-007 SHALL provide port sel  output  8  one-hot register select (drive-onto-data-bus) strobes, same bit mapping as ld.
REQ-008 SHALL provide port busy  output  1  high while a move is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse marking completion of an accepted legal move.
REQ-010 SHALL provide port illegal  output  1  one-cycle pulse on rejection of an instr with bits[7:6] != 00.

Function
REQ-011 SHALL implement states IDLE, SEL, LOAD, HOLD, FIN; all outputs SHALL be registered.
REQ-012 In IDLE with start=1 and instr[7:6]=00, SHALL latch instr and enter SEL on that edge.
REQ-013 In IDLE with start=1 and instr[7:6]!=00, SHALL stay in IDLE, pulse illegal for the next cycle, and assert no ld or sel bit.
REQ-014 SEL SHALL last exactly SETTLE cycles, timed by a 4-bit counter, with sel[src]=1, ld=0, busy=1.
REQ-015 LOAD SHALL last 1 cycle with sel[src]=1, ld[dst]=1, busy=1.
REQ-016 HOLD SHALL last 1 cycle with sel[src]=1, ld=0, busy=1, so the source stays on the bus while the destination latch closes.
REQ-017 FIN SHALL last 1 cycle with sel=0, ld=0, busy=0, done=1, then return to IDLE.
REQ-018 For a legal move, the latency from the accepting edge to the done pulse SHALL be SETTLE+3 cycles; no new start SHALL be accepted until IDLE is re-entered.
REQ-019 start asserted outside IDLE SHALL be ignored, not queued; instr changes after acceptance SHALL have no effect.
REQ-020 If src==dst (clear move), sel SHALL remain all-zero in every state so the bus floats to 0, while ld[dst] pulses in LOAD as normal.
REQ-021 At most one bit of ld and at most one bit of sel SHALL be high in any cycle; ld and sel SHALL never both select the same register.
REQ-022 done and illegal SHALL never be high in the same cycle.

Reset
REQ-023 reset=1 SHALL asynchronously force IDLE, counter=0, ld=0, sel=0, busy=0, done=0, illegal=0, and clear the latched instr.
REQ-024 Reset asserted mid-move SHALL abort the move with no subsequent ld pulse; the first start after deassertion SHALL be accepted normally.

Verification
REQ-025 SETTLE=1, instr=0x08 (B<-A), start for 1 cycle -> sel=0x01 for 3 cycles, ld=0x02 in the 2nd of those cycles, done on cycle 4, busy high in cycles 1..3.
REQ-026 SETTLE=3, instr=0x3E (Y<-X) -> sel=0x40 for 5 cycles, ld=0x80 in cycle 4 only, done in cycle 6.
REQ-027 instr=0x12 (C<-C, clear) -> sel=0x00 throughout, ld=0x04 in LOAD, done at SETTLE+3.
REQ-028 instr=0x48 -> illegal pulse of 1 cycle; ld, sel, busy and done stay 0.
REQ-029 Second start during busy with a different instr -> ignored; exactly one done pulse, and ld reflects only the first instr.
REQ-030 reset pulsed during LOAD -> ld and sel go to 0 immediately without waiting for a clock edge, no done pulse; a subsequent start of 0x21 (M1<-B) completes normally.

Source files
------------

// File: rtl/register_move_sequencer.sv
// register_move_sequencer: sequences a single MOV8 register-to-register move.
// The source register drives the data bus for SETTLE cycles, the destination
// load strobe fires for one cycle, the source is held one more cycle while the
// destination latch closes, and a one-cycle done pulse ends the move.
// A source equal to the destination is a clear move: the bus is left floating
// (reads 0) and only the destination load fires.
module register_move_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [7:0] ld,
  output logic [7:0] sel,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    LOAD,
    HOLD,
    FIN
  } state_t;

  // Counter preload so that SEL lasts exactly SETTLE cycles (counts down to 0).
  localparam logic [3:0] SETTLE_PRELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settleCnt;
  logic [5:0] moveReg;  // latched ddd sss fields; opcode bits are checked, not kept

  // One-hot source select for a move word; all-zero for a clear move.
  function automatic logic [7:0] selFor(input logic [5:0] word);
    if (word[5:3] == word[2:0]) begin
      selFor = 8'h00;
    end else begin
      selFor = 8'h01 << word[2:0];
    end
  endfunction

  // One-hot destination load for a move word.
  function automatic logic [7:0] ldFor(input logic [5:0] word);
    ldFor = 8'h01 << word[5:3];
  endfunction

  // Sequencer state, settle counter, latched move and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      settleCnt <= 4'd0;
      moveReg   <= 6'd0;
      ld        <= 8'h00;
      sel       <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every case arm sees the
      // pre-edge state and these pulse defaults are simply overridden below.
      ld      <= 8'h00;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (instr[7:6] == 2'b00) begin
              moveReg   <= instr[5:0];
              settleCnt <= SETTLE_PRELOAD;
              sel       <= selFor(instr[5:0]);
              busy      <= 1'b1;
              state     <= SEL;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        SEL: begin
          if (settleCnt == 4'd0) begin
            ld    <= ldFor(moveReg);
            state <= LOAD;
          end else begin
            settleCnt <= settleCnt - 4'd1;
          end
        end
        LOAD: begin
          state <= HOLD;
        end
        HOLD: begin
          sel   <= 8'h00;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          sel   <= 8'h00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
